// File: rtl/ch_adv_tx_if.sv
// Byte-stream valid/ready link from the advertisement transmitter to the radio/packet buffer.
interface ch_adv_tx_if #(
    parameter int BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/ch_adv_tx.sv
// Cluster-head advertisement transmitter: latches one advert on en_TX and streams it
// as a 10-byte MSB-first packet with a trailing XOR checksum.
module ch_adv_tx #(
    parameter int                   WORD_WIDTH = 16,
    parameter int                   BYTE_WIDTH = 8,
    parameter logic [BYTE_WIDTH-1:0] TYPE_ORIG  = 8'h02,
    parameter logic [BYTE_WIDTH-1:0] TYPE_RELAY = 8'h03
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_TX,
    input  logic                  relay,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] adv_ID,
    input  logic [WORD_WIDTH-1:0] adv_Hops,
    input  logic [WORD_WIDTH-1:0] adv_QValue,
    input  logic [WORD_WIDTH-1:0] adv_CHlimit,
    ch_adv_tx_if.master           tx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'd9;

    state_t                state, state_nxt;
    logic [3:0]            idx, idx_nxt;
    logic                  latch;
    logic                  handshake;
    logic [BYTE_WIDTH-1:0] type_r;
    logic [WORD_WIDTH-1:0] id_r, hops_r, q_r, lim_r;
    logic [BYTE_WIDTH-1:0] cur_byte;

    // Relay hop increment sticks at all-ones rather than wrapping to zero.
    function automatic logic [WORD_WIDTH-1:0] sat_inc(input logic [WORD_WIDTH-1:0] v);
        if (v == {WORD_WIDTH{1'b1}})
            return v;
        return v + 1'b1;
    endfunction

    function automatic logic [BYTE_WIDTH-1:0] hi(input logic [WORD_WIDTH-1:0] w);
        return w[WORD_WIDTH-1 -: BYTE_WIDTH];
    endfunction

    function automatic logic [BYTE_WIDTH-1:0] lo(input logic [WORD_WIDTH-1:0] w);
        return w[BYTE_WIDTH-1:0];
    endfunction

    function automatic logic [BYTE_WIDTH-1:0] pkt_byte(input logic [3:0] i);
        logic [BYTE_WIDTH-1:0] b;
        case (i)
            4'd0:    b = type_r;
            4'd1:    b = hi(id_r);
            4'd2:    b = lo(id_r);
            4'd3:    b = hi(hops_r);
            4'd4:    b = lo(hops_r);
            4'd5:    b = hi(q_r);
            4'd6:    b = lo(q_r);
            4'd7:    b = hi(lim_r);
            4'd8:    b = lo(lim_r);
            4'd9:    b = type_r ^ hi(id_r) ^ lo(id_r) ^ hi(hops_r) ^ lo(hops_r)
                       ^ hi(q_r) ^ lo(q_r) ^ hi(lim_r) ^ lo(lim_r);
            default: b = '0;
        endcase
        return b;
    endfunction

    assign handshake = (state == SEND) && tx.tx_ready;
    assign cur_byte  = pkt_byte(idx);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (en_TX) begin
                    latch     = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // Abort wins over a same-cycle handshake.
                if (abort) begin
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else if (handshake) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            type_r <= '0;
            id_r   <= '0;
            hops_r <= '0;
            q_r    <= '0;
            lim_r  <= '0;
        end else if (latch) begin
            type_r <= relay ? TYPE_RELAY : TYPE_ORIG;
            id_r   <= adv_ID;
            hops_r <= relay ? sat_inc(adv_Hops) : adv_Hops;
            q_r    <= adv_QValue;
            lim_r  <= adv_CHlimit;
        end
    end

    // Outputs are decoded from state so reset forces them low immediately.
    assign tx.tx_valid = (state == SEND);
    assign tx.tx_data  = (state == SEND) ? cur_byte : '0;
    assign tx.tx_last  = (state == SEND) && (idx == LAST_IDX);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_ch_adv_tx.sv
// Directed bench for ch_adv_tx: hand-computed packets checked byte by byte with immediate assertions.
module tb_ch_adv_tx;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en_TX = 1'b0;
    logic        relay = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] adv_ID = '0;
    logic [15:0] adv_Hops = '0;
    logic [15:0] adv_QValue = '0;
    logic [15:0] adv_CHlimit = '0;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt_orig  [10];
    logic [7:0] pkt_sat   [10];
    logic [7:0] pkt_relay [10];

    ch_adv_tx_if #(.BYTE_WIDTH(8)) link ();

    ch_adv_tx dut (
        .clk         (clk),
        .nrst        (nrst),
        .en_TX       (en_TX),
        .relay       (relay),
        .abort       (abort),
        .adv_ID      (adv_ID),
        .adv_Hops    (adv_Hops),
        .adv_QValue  (adv_QValue),
        .adv_CHlimit (adv_CHlimit),
        .tx          (link.master),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_pkt(input logic rel);
        relay = rel;
        en_TX = 1'b1;
        step();
        en_TX = 1'b0;
    endtask

    // Streams one started packet; optional stall or mid-packet poke at a byte index.
    task automatic run_pkt(input string tag, input logic [7:0] exp [10],
                           input int stall_at, input int poke_at);
        for (int i = 0; i < 10; i++) begin
            if (i == stall_at) begin
                link.tx_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk({tag, "_stall_data"}, link.tx_data, exp[i]);
                    chk({tag, "_stall_valid"}, link.tx_valid, 1'b1);
                    chk({tag, "_stall_last"}, link.tx_last, 1'b0);
                end
                link.tx_ready = 1'b1;
            end
            if (i == poke_at) begin
                adv_ID = 16'h0099;
                en_TX  = 1'b1;
            end
            chk($sformatf("%s_b%0d", tag, i), link.tx_data, exp[i]);
            chk($sformatf("%s_valid%0d", tag, i), link.tx_valid, 1'b1);
            chk($sformatf("%s_last%0d", tag, i), link.tx_last, (i == 9));
            chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            chk($sformatf("%s_done%0d", tag, i), done, 1'b0);
            step();
            en_TX = 1'b0;
        end
        chk({tag, "_done_pulse"}, done, 1'b1);
        chk({tag, "_done_valid"}, link.tx_valid, 1'b0);
        chk({tag, "_done_busy"}, busy, 1'b1);
        step();
        chk({tag, "_done_clear"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_valid"}, link.tx_valid, 1'b0);
    endtask

    initial begin
        pkt_orig  = '{8'h02, 8'h00, 8'h17, 8'h00, 8'h02, 8'h30, 8'h00, 8'h00, 8'h03, 8'h24};
        pkt_sat   = '{8'h03, 8'h00, 8'h17, 8'hFF, 8'hFF, 8'h30, 8'h00, 8'h00, 8'h03, 8'h27};
        pkt_relay = '{8'h03, 8'h00, 8'h17, 8'h00, 8'h03, 8'h30, 8'h00, 8'h00, 8'h03, 8'h24};
        link.tx_ready = 1'b1;

        repeat (3) step();
        chk("rst_valid", link.tx_valid, 1'b0);
        chk("rst_data", link.tx_data, 8'h00);
        chk("rst_last", link.tx_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        nrst = 1'b1;
        step();
        chk("idle_valid", link.tx_valid, 1'b0);

        adv_ID = 16'h0017; adv_Hops = 16'h0002; adv_QValue = 16'h3000; adv_CHlimit = 16'h0003;
        start_pkt(1'b0);
        run_pkt("orig", pkt_orig, -1, -1);

        // en_TX together with abort in IDLE still starts the packet.
        adv_Hops = 16'hFFFF;
        abort = 1'b1;
        start_pkt(1'b1);
        abort = 1'b0;
        run_pkt("relay_sat", pkt_sat, -1, -1);

        adv_Hops = 16'h0002;
        start_pkt(1'b1);
        relay = 1'b0;
        run_pkt("relay", pkt_relay, -1, -1);

        start_pkt(1'b0);
        run_pkt("stall", pkt_orig, 4, -1);

        start_pkt(1'b0);
        run_pkt("poke", pkt_orig, -1, 3);
        step();
        chk("poke_no_second", link.tx_valid, 1'b0);
        adv_ID = 16'h0017;

        // Abort at byte 5, with ready high.
        start_pkt(1'b0);
        repeat (5) step();
        chk("abort_b5", link.tx_data, 8'h30);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", link.tx_valid, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_busy", busy, 1'b0);
        step();
        chk("abort_done_late", done, 1'b0);
        start_pkt(1'b0);
        run_pkt("post_abort", pkt_orig, -1, -1);

        // Asynchronous reset at byte 7.
        start_pkt(1'b0);
        repeat (7) step();
        chk("arst_b7", link.tx_data, 8'h00);
        chk("arst_last_pre", link.tx_last, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_valid", link.tx_valid, 1'b0);
        chk("arst_data", link.tx_data, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        step();
        chk("arst_hold_done", done, 1'b0);
        nrst = 1'b1;
        step();
        chk("arst_idle", link.tx_valid, 1'b0);
        start_pkt(1'b0);
        run_pkt("post_rst", pkt_orig, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
